// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants and types for the KGPMini data-memory arbiter.
//   DMEM_ADDR_W / DMEM_DATA_W : default word-address and data widths
//   PORT_CPU / PORT_LDR       : port indices (CPU load/store, loader/debug)
//   dmem_req_t                : one access request {we, addr, wdata}
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way arbiter, round-robin or fixed priority (port 0 first), holding the
// last_grant register. A force0 input lets the caller pin ownership to port 0.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   req[1:0]       : per-port request
//   force0         : port 0 wins whenever it requests
//   gnt[1:0]       : one-hot (or zero) grant, combinational from req + state
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       force0,
    output logic [1:0] gnt
);

    logic last_grant;

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    always_comb begin
        gnt = 2'b00;
        if (force0 && req[0]) begin
            gnt = 2'b01;
        end else if (req == 2'b11) begin
            // On a tie, round-robin hands the slot to the port that did not
            // win last; fixed priority always picks port 0.
            gnt = (RR_EN && (last_grant == PORT_CPU)) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= PORT_LDR;  // port 0 wins the first tie
        end else if (|gnt) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported KGPMini data memory between the CPU load/store
// stage (port 0) and the loader/debug port (port 1). One access per cycle;
// read data returns one cycle after the grant and is steered to the issuer.
// Ports:
//   clk, reset                       : clock, asynchronous active-low reset
//   p0_req/we/lock/addr/wdata        : port 0 request (lock = keep ownership)
//   p0_gnt, p0_rvalid, p0_rdata      : port 0 grant and read return
//   p1_req/we/addr/wdata             : port 1 request (no lock)
//   p1_gnt, p1_rvalid, p1_rdata      : port 1 grant and read return
//   mem_addr/wdata/write/read        : memory controls (zero when idle/reset)
//   mem_rdata                        : memory registered read data
// The request bundle is sized by dmem_pkg, so ADDR_W/DATA_W must match
// DMEM_ADDR_W/DMEM_DATA_W.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       lock_active;   // port 0 owns the memory (lock_owner = 0)
    logic       rd_pend;
    logic       rd_tag;
    dmem_req_t  p0_bundle;
    dmem_req_t  p1_bundle;
    dmem_req_t  win;

    // Masking requests with reset forces every grant and memory control low
    // while reset is held, without waiting for a clock.
    assign req = {p1_req, p0_req} & {2{reset}};

    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .force0 (lock_active),
        .gnt    (gnt)
    );

    assign p0_gnt  = gnt[0];
    assign p1_gnt  = gnt[1];
    assign any_gnt = |gnt;

    assign p0_bundle = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
    assign p1_bundle = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};

    always_comb begin
        win       = gnt[1] ? p1_bundle : p0_bundle;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (any_gnt) begin
            mem_addr  = win.addr;
            mem_wdata = win.wdata;
            mem_write = win.we;
            mem_read  = ~win.we;
        end
    end

    // Lock is taken when port 0 is granted with p0_lock set and survives only
    // while port 0 keeps both req and lock asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_active <= 1'b0;
        end else begin
            lock_active <= p0_req && p0_lock && (lock_active || gnt[0]);
        end
    end

    // One-deep tag pipeline matching the memory's 1-cycle read latency.
    // Clearing rd_pend on reset drops any in-flight return for good.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend <= 1'b0;
            rd_tag  <= PORT_CPU;
        end else begin
            rd_pend <= mem_read;
            if (mem_read) begin
                rd_tag <= gnt[1];
            end
        end
    end

    assign p0_rvalid = rd_pend && (rd_tag == PORT_CPU);
    assign p1_rvalid = rd_pend && (rd_tag == PORT_LDR);
    assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Bench for dmem_arbiter: a round-robin instance and a fixed-priority instance,
// each in front of a behavioural registered-read memory. Read expectations are
// queued when a grant is expected and checked when the return cycle arrives.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          p0_req = 0, p0_we = 0, p0_lock = 0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req = 0, p1_we = 0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          fp_p0_req = 0, fp_p1_req = 0;

    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_write, mem_read;

    logic          fp_p0_gnt, fp_p0_rvalid, fp_p1_gnt, fp_p1_rvalid;
    logic [DW-1:0] fp_p0_rdata, fp_p1_rdata;
    logic [AW-1:0] fp_mem_addr;
    logic [DW-1:0] fp_mem_wdata, fp_mem_rdata;
    logic          fp_mem_write, fp_mem_read;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_req(fp_p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(fp_p0_gnt), .p0_rvalid(fp_p0_rvalid),
        .p0_rdata(fp_p0_rdata),
        .p1_req(fp_p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(fp_p1_gnt), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_write(fp_mem_write),
        .mem_read(fp_mem_read), .mem_rdata(fp_mem_rdata)
    );

    // Behavioural single-port memories: write and registered read on the edge.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    logic [DW-1:0] fp_ram [0:(1<<AW)-1];
    logic [DW-1:0] fp_ram_q;

    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
        if (mem_read)  ram_q <= ram[mem_addr];
        if (fp_mem_write) fp_ram[fp_mem_addr] <= fp_mem_wdata;
        if (fp_mem_read)  fp_ram_q <= fp_ram[fp_mem_addr];
    end
    assign mem_rdata    = ram_q;
    assign fp_mem_rdata = fp_ram_q;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    int            n_checks = 0;
    int            n_pass = 0;

    // One cycle of stimulus on the round-robin instance. eg is the grant the
    // bench expects this cycle; it drives the model memory and the read queue.
    task automatic step(input logic r0, input logic we0, input logic lk0,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic we1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [1:0] eg);
        exp_t          e;
        logic          v0, v1;
        logic [DW-1:0] e0, e1;
        @(negedge clk);
        p0_req = r0; p0_we = we0; p0_lock = lk0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
        #1;
        v0 = 1'b0; v1 = 1'b0; e0 = '0; e1 = '0;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port == PORT_LDR) begin v1 = 1'b1; e1 = e.data; end
            else begin v0 = 1'b1; e0 = e.data; end
        end
        n_checks++;
        if ({p0_rvalid, p1_rvalid, p0_rdata, p1_rdata} !== {v0, v1, e0, e1})
            $display("FAIL read_return t=%0t: got rv0=%b rv1=%b rd0=%h rd1=%h, want rv0=%b rv1=%b rd0=%h rd1=%h",
                     $time, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, v0, v1, e0, e1);
        else n_pass++;
        if (eg[0]) begin
            if (we0) model_mem[a0] = d0;
            else begin e.port = PORT_CPU; e.data = model_mem[a0]; sb.push_back(e); end
        end
        if (eg[1]) begin
            if (we1) model_mem[a1] = d1;
            else begin e.port = PORT_LDR; e.data = model_mem[a1]; sb.push_back(e); end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        p0_req = 0; p1_req = 0; p0_lock = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        p0_req = 1; p0_we = 1; p0_addr = 10'd4; p0_wdata = 32'h44;
        p1_req = 1; p1_we = 1; p1_addr = 10'd6; p1_wdata = 32'h66;
        fp_p0_req = 1; fp_p1_req = 1;
        #12;
        n_checks++;
        if ({p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
             mem_addr, mem_wdata, mem_write, mem_read} !== '0)
            $display("FAIL reset_outputs: got gnt=%b%b mem_w=%b mem_r=%b addr=%h, want all zero",
                     p1_gnt, p0_gnt, mem_write, mem_read, mem_addr);
        else n_pass++;
        n_checks++;
        if ({fp_p0_gnt, fp_p1_gnt, fp_mem_write, fp_mem_read, fp_mem_addr} !== '0)
            $display("FAIL reset_outputs_fp: got gnt=%b%b mem_w=%b mem_r=%b, want zero",
                     fp_p1_gnt, fp_p0_gnt, fp_mem_write, fp_mem_read);
        else n_pass++;
        fp_p0_req = 0; fp_p1_req = 0;
        // Release with both requests held: they are arbitrated in that cycle.
        @(posedge clk);
        #2;
        reset = 1'b1;
        step(1, 1, 0, 10'd4, 32'h44, 1, 1, 10'd6, 32'h66, 2'b01);
        n_checks++;
        if ({p1_gnt, p0_gnt, mem_write, mem_read, mem_addr} !== {2'b01, 1'b1, 1'b0, 10'd4})
            $display("FAIL reset_release_first_tie: got gnt=%b%b w=%b r=%b addr=%h, want gnt=01 w=1 r=0 addr=004",
                     p1_gnt, p0_gnt, mem_write, mem_read, mem_addr);
        else n_pass++;
        step(0, 0, 0, 10'd0, 32'h0, 1, 1, 10'd6, 32'h66, 2'b10);
        n_checks++;
        if ({p1_gnt, p0_gnt, mem_addr, mem_wdata} !== {2'b10, 10'd6, 32'h66})
            $display("FAIL reset_release_second: got gnt=%b%b addr=%h wd=%h, want gnt=10 addr=006 wd=00000066",
                     p1_gnt, p0_gnt, mem_addr, mem_wdata);
        else n_pass++;
    endtask

    task automatic test_single_port();
        step(1, 1, 0, 10'd5, 32'hDEADBEEF, 0, 0, 10'd0, 32'h0, 2'b01);
        n_checks++;
        if ({p0_gnt, p1_gnt, mem_write, mem_read, mem_addr, mem_wdata} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 10'd5, 32'hDEADBEEF})
            $display("FAIL single_write: got gnt0=%b w=%b r=%b addr=%h wd=%h, want gnt0=1 w=1 r=0 addr=005 wd=deadbeef",
                     p0_gnt, mem_write, mem_read, mem_addr, mem_wdata);
        else n_pass++;
        step(1, 0, 0, 10'd5, 32'h0, 0, 0, 10'd0, 32'h0, 2'b01);
        n_checks++;
        if ({p0_gnt, mem_write, mem_read, mem_addr} !== {1'b1, 1'b0, 1'b1, 10'd5})
            $display("FAIL single_read: got gnt0=%b w=%b r=%b addr=%h, want gnt0=1 w=0 r=1 addr=005",
                     p0_gnt, mem_write, mem_read, mem_addr);
        else n_pass++;
        step(0, 0, 0, 10'd0, 32'h0, 0, 0, 10'd0, 32'h0, 2'b00);
    endtask

    task automatic test_round_robin();
        step(0, 0, 0, 10'd0, 32'h0, 1, 1, 10'd1, 32'h11, 2'b10);
        step(0, 0, 0, 10'd0, 32'h0, 1, 1, 10'd2, 32'h22, 2'b10);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            step(1, 0, 0, 10'd1, 32'h0, 1, 0, 10'd2, 32'h0, exp_g);
            n_checks++;
            if ({p1_gnt, p0_gnt} !== exp_g)
                $display("FAIL rr_grant[%0d]: got %b%b, want %b", i, p1_gnt, p0_gnt, exp_g);
            else n_pass++;
        end
        step(0, 0, 0, 10'd0, 32'h0, 0, 0, 10'd0, 32'h0, 2'b00);
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        p1_we = 1; p1_addr = 10'd1; p1_wdata = 32'h11;
        fp_p1_req = 1; fp_p0_req = 0;
        #1;
        n_checks++;
        if ({fp_p1_gnt, fp_mem_write} !== 2'b11)
            $display("FAIL fp_preload: got gnt1=%b w=%b, want 1 1", fp_p1_gnt, fp_mem_write);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            p0_we = 0; p0_lock = 0; p0_addr = 10'd1;
            p1_we = 0; p1_addr = 10'd2;
            fp_p0_req = 1; fp_p1_req = 1;
            #1;
            n_checks++;
            if ({fp_p0_gnt, fp_p1_gnt} !== 2'b10)
                $display("FAIL fp_grant[%0d]: got gnt0=%b gnt1=%b, want 1 0", i, fp_p0_gnt, fp_p1_gnt);
            else n_pass++;
            n_checks++;
            if ({fp_p0_rvalid, fp_p1_rvalid, fp_p0_rdata} !==
                {(i > 0), 1'b0, ((i > 0) ? 32'h11 : 32'h0)})
                $display("FAIL fp_return[%0d]: got rv0=%b rv1=%b rd0=%h", i, fp_p0_rvalid,
                         fp_p1_rvalid, fp_p0_rdata);
            else n_pass++;
        end
        @(negedge clk);
        fp_p0_req = 0; fp_p1_req = 0;
    endtask

    task automatic test_lock();
        step(0, 0, 0, 10'd0, 32'h0, 1, 1, 10'd9, 32'hA5A5A5A5, 2'b10);
        step(1, 0, 1, 10'd9, 32'h0, 1, 0, 10'd9, 32'h0, 2'b01);
        n_checks++;
        if ({p1_gnt, p0_gnt} !== 2'b01)
            $display("FAIL lock_read_grant: got %b%b, want 01", p1_gnt, p0_gnt);
        else n_pass++;
        // Round-robin alone would now pick port 1; the lock keeps port 0.
        step(1, 1, 0, 10'd9, 32'h12345678, 1, 0, 10'd9, 32'h0, 2'b01);
        n_checks++;
        if ({p1_gnt, p0_gnt, mem_write} !== 3'b011)
            $display("FAIL lock_write_grant: got gnt=%b%b w=%b, want gnt=01 w=1",
                     p1_gnt, p0_gnt, mem_write);
        else n_pass++;
        step(0, 0, 0, 10'd0, 32'h0, 1, 0, 10'd9, 32'h0, 2'b10);
        n_checks++;
        if ({p1_gnt, p0_gnt} !== 2'b10)
            $display("FAIL lock_release_grant: got %b%b, want 10", p1_gnt, p0_gnt);
        else n_pass++;
        step(0, 0, 0, 10'd0, 32'h0, 0, 0, 10'd0, 32'h0, 2'b00);
    endtask

    task automatic test_back_to_back();
        step(1, 1, 0, 10'd7, 32'hCAFEF00D, 0, 0, 10'd0, 32'h0, 2'b01);
        step(0, 0, 0, 10'd0, 32'h0, 1, 0, 10'd7, 32'h0, 2'b10);
        n_checks++;
        if ({p1_gnt, mem_read, mem_addr} !== {1'b1, 1'b1, 10'd7})
            $display("FAIL raw_read_grant: got gnt1=%b r=%b addr=%h, want 1 1 007",
                     p1_gnt, mem_read, mem_addr);
        else n_pass++;
        step(1, 0, 0, 10'd7, 32'h0, 1, 0, 10'd5, 32'h0, 2'b01);
        step(1, 0, 0, 10'd7, 32'h0, 1, 0, 10'd5, 32'h0, 2'b10);
        n_checks++;
        if ({p1_gnt, p0_gnt, mem_addr} !== {2'b10, 10'd5})
            $display("FAIL b2b_alt_grant: got gnt=%b%b addr=%h, want 10 005", p1_gnt, p0_gnt, mem_addr);
        else n_pass++;
        step(1, 0, 0, 10'd5, 32'h0, 0, 0, 10'd0, 32'h0, 2'b01);
        step(0, 0, 0, 10'd0, 32'h0, 0, 0, 10'd0, 32'h0, 2'b00);
    endtask

    task automatic test_reset_mid_read();
        step(0, 0, 0, 10'd0, 32'h0, 1, 1, 10'd3, 32'h33, 2'b10);
        step(0, 0, 0, 10'd0, 32'h0, 1, 0, 10'd3, 32'h0, 2'b10);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
             mem_addr, mem_wdata, mem_write, mem_read} !== '0)
            $display("FAIL mid_reset_outputs: got rv1=%b rd1=%h gnt1=%b r=%b, want all zero",
                     p1_rvalid, p1_rdata, p1_gnt, mem_read);
        else n_pass++;
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        step(0, 0, 0, 10'd0, 32'h0, 1, 0, 10'd3, 32'h0, 2'b10);
        n_checks++;
        if ({p1_gnt, mem_read, mem_addr} !== {1'b1, 1'b1, 10'd3})
            $display("FAIL post_reset_grant: got gnt1=%b r=%b addr=%h, want 1 1 003",
                     p1_gnt, mem_read, mem_addr);
        else n_pass++;
        step(0, 0, 0, 10'd0, 32'h0, 0, 0, 10'd0, 32'h0, 2'b00);
        step(0, 0, 0, 10'd0, 32'h0, 0, 0, 10'd0, 32'h0, 2'b00);
    endtask

    task automatic test_idle_write_only();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 10'd0, 32'h0, 0, 0, 10'd0, 32'h0, 2'b00);
            n_checks++;
            if ({mem_read, mem_write, p0_gnt, p1_gnt} !== 4'b0000)
                $display("FAIL idle[%0d]: got r=%b w=%b gnt=%b%b, want 0", i, mem_read,
                         mem_write, p1_gnt, p0_gnt);
            else n_pass++;
        end
        step(0, 0, 0, 10'd0, 32'h0, 1, 1, 10'd8, 32'h88, 2'b10);
        n_checks++;
        if ({p1_gnt, mem_write, mem_read} !== 3'b110)
            $display("FAIL write_only: got gnt1=%b w=%b r=%b, want 1 1 0", p1_gnt, mem_write, mem_read);
        else n_pass++;
        step(0, 0, 0, 10'd0, 32'h0, 0, 0, 10'd0, 32'h0, 2'b00);
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_fixed_priority();
        test_lock();
        test_back_to_back();
        test_reset_mid_read();
        test_idle_write_only();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory of the KGPMini RISC processor between two requesters.
- Port 0 is the CPU load/store stage. Port 1 is the program/data loader and debug port.
- Owns the memory control signals (MemRead/MemWrite/address/write data) and arbitrates one access per cycle.
- Tracks the memory's 1-cycle registered read latency and routes the returned word to the requester that issued the read.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, data word width.
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority with port 0 winning.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- p0_req  in  1  port 0 access request; held with fields stable until p0_gnt.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_lock  in  1  port 0 keeps ownership on following cycles (read-modify-write).
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 request accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DATA_W  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1. Port 1 has no lock input.
- mem_addr  out  ADDR_W  to memory address_in.
- mem_wdata  out  DATA_W  to memory write_data.
- mem_write  out  1  to memory MemWrite.
- mem_read  out  1  to memory MemRead.
- mem_rdata  in  DATA_W  from memory data_out.

Behaviour:
- Reset (reset=0, asynchronous) clears all registers:
  - last_grant = 1, so port 0 wins the first tie.
  - lock_owner = none.
  - rd_pend = 0, rd_tag = 0.
  - All outputs are 0 during reset, including the gnt and mem_* signals, which are forced low while reset=0.
- Arbitration is combinational within a cycle and uses only registered state:
  - Only one port requesting: that port wins.
  - Both requesting, RR_EN=1: the port not equal to last_grant wins.
  - Both requesting, RR_EN=0: port 0 wins.
  - lock_owner=0: port 0 wins whenever p0_req=1, regardless of port 1.
- Grant cycle: pX_gnt=1 and mem_addr/mem_wdata are muxed from the winner.
  - mem_write = winner.we.
  - mem_read = ~winner.we.
  - With no requester, mem_read=0 and mem_write=0.
  - A request is consumed at the rising edge where its gnt=1. The requester drops req or presents a new request in the next cycle.
- On each granted edge: last_grant <= winner.
- Lock handling:
  - lock_owner <= 0 when port 0 is granted with p0_lock=1.
  - lock_owner clears on any edge where p0_lock=0 or p0_req=0.
  - A locked port 0 may issue back-to-back read then write, one per cycle.
- Read return latency is exactly 1 cycle:
  - A read granted in cycle N sets rd_pend=1 and rd_tag=winner at edge N.
  - In cycle N+1, pX_rvalid=1 for the tagged port and pX_rdata=mem_rdata.
- Read data gating: pX_rdata = 0 whenever pX_rvalid = 0. The other port's rdata is also 0.
- Back-to-back reads, including alternating ports, give one rvalid per cycle; throughput is 1 access/cycle.
- A write grant produces no rvalid.
- Read-after-write to the same address in consecutive cycles returns the new data, because the memory updates on the write edge.
- Reset asserted mid-read: the pending rvalid is discarded and is not re-issued after reset.
- Requests seen in the same cycle as reset deassertion are arbitrated normally.

Decomposition:
- Shared package dmem_pkg:
  - Constants DMEM_ADDR_W=10 and DMEM_DATA_W=32.
  - Port index constants PORT_CPU=0 and PORT_LDR=1.
  - Typedef for the request bundle {we, addr, wdata}.
- Sub-module rr_arb2: 2-way round-robin/fixed-priority arbiter holding the last_grant register.
- The top level adds the lock logic, the memory mux and the read-return tag pipeline.

Test Plan:
- Reset then single port-0 write: p0 write addr=5 data=0xDEADBEEF, then p0 read addr=5.
  - Expect p0_gnt in the request cycle, mem_write=1 in cycle 0.
  - Expect p0_rvalid=1 with p0_rdata=0xDEADBEEF exactly one cycle after the read grant; p1_rvalid stays 0.
- Round-robin contention, RR_EN=1: both ports read continuously for 6 cycles (p0 addr=1, p1 addr=2, preloaded 0x11/0x22).
  - Grants alternate 0,1,0,1,0,1.
  - rvalid alternates one cycle later with the correct data.
- Fixed priority, RR_EN=0, same stimulus: p0_gnt every cycle and p1_gnt never, while p0_req=1.
- Lock: p0 reads addr=9 with p0_lock=1 while p1_req=1 continuously, then p0 writes addr=9.
  - Port 1 is not granted until the cycle after p0_lock drops.
  - The write value 0x12345678 is read back by port 1.
- Reset mid-operation: assert reset=0 asynchronously in the cycle after a granted p1 read of addr=3.
  - p1_rvalid=0 immediately and all outputs are 0.
  - After release, the first p1 request is served normally.
- Idle and write-only: no requests gives mem_read=mem_write=0 and rdata=0 for 10 cycles. A p1 write produces no rvalid on either port.
